seven_seg_scan: RTL and testbench



---
 rtl/seven_seg_scan.sv | 158 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with double-buffered display data,
// programmable per-slot brightness (guard sub-slot 0) and a frame strobe.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int CLKSPEED       = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DUTY_BITS      = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic [4*DIGITS-1:0]    value,
  input  logic [DIGITS-1:0]      dp,
  input  logic [DIGITS-1:0]      blank,
  input  logic [DUTY_BITS-1:0]   duty,
  input  logic                   load,
  output logic [6:0]             seg,
  output logic                   seg_dp,
  output logic [DIGITS-1:0]      an,
  output logic                   frame
);

  localparam int DIV_RAW = CLKSPEED / (SCAN_HZ << DUTY_BITS);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]        PRE_LAST   = PW'(DIV - 1);
  localparam logic [DW-1:0]        D_LAST     = DW'(DIGITS - 1);
  localparam logic [DUTY_BITS-1:0] S_LAST     = '1;
  localparam logic [6:0]           SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                 SEG_DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0]    AN_OFF     = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]        pre_reg;
  logic [DUTY_BITS-1:0] s_reg;
  logic [DW-1:0]        d_reg;
  logic                 tick;
  logic                 s_wrap;
  logic                 boundary;

  assign tick     = (pre_reg == PRE_LAST);
  assign s_wrap   = tick && (s_reg == S_LAST);
  assign boundary = s_wrap && (d_reg == D_LAST);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pre_reg <= '0;
      s_reg   <= '0;
      d_reg   <= '0;
    end else begin
      pre_reg <= tick ? '0 : pre_reg + PW'(1);
      if (tick)
        s_reg <= s_reg + DUTY_BITS'(1);
      if (s_wrap)
        d_reg <= boundary ? '0 : d_reg + DW'(1);
    end
  end

  logic [4*DIGITS-1:0]  sh_value_reg;
  logic [DIGITS-1:0]    sh_dp_reg;
  logic [DIGITS-1:0]    sh_blank_reg;
  logic [DUTY_BITS-1:0] sh_duty_reg;
  logic                 pending_reg;
  logic [4*DIGITS-1:0]  act_value_reg;
  logic [DIGITS-1:0]    act_dp_reg;
  logic [DIGITS-1:0]    act_blank_reg;
  logic [DUTY_BITS-1:0] act_duty_reg;

  // A load coinciding with a transfer: active takes the old shadow, the new
  // data lands in shadow and stays pending for the following frame.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sh_value_reg  <= '0;
      sh_dp_reg     <= '0;
      sh_blank_reg  <= '0;
      sh_duty_reg   <= '0;
      pending_reg   <= 1'b0;
      act_value_reg <= '0;
      act_dp_reg    <= '0;
      act_blank_reg <= '1;
      act_duty_reg  <= '0;
    end else begin
      if (boundary && pending_reg) begin
        act_value_reg <= sh_value_reg;
        act_dp_reg    <= sh_dp_reg;
        act_blank_reg <= sh_blank_reg;
        act_duty_reg  <= sh_duty_reg;
      end
      if (load) begin
        sh_value_reg <= value;
        sh_dp_reg    <= dp;
        sh_blank_reg <= blank;
        sh_duty_reg  <= duty;
        pending_reg  <= 1'b1;
      end else if (boundary) begin
        pending_reg  <= 1'b0;
      end
    end
  end

  logic [3:0]        act_nib [DIGITS];
  logic [DIGITS-1:0] an_next;
  logic              lit;

  assign lit = !act_blank_reg[d_reg] && (s_reg != '0) && (s_reg <= act_duty_reg);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign act_nib[gi] = act_value_reg[4*gi +: 4];
    assign an_next[gi] = lit && (d_reg == DW'(gi));
  end

  logic [3:0] cur_nib;
  logic [6:0] hex_seg;

  assign cur_nib = act_nib[d_reg];

  always_comb begin
    hex_seg = 7'h00;
    case (cur_nib)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
      default: hex_seg = 7'h00;
    endcase
  end

  // Pins are registered, so they trail the scan state by one clock; frame is
  // timed to the first output edge of state d=0, s=0.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      an     <= AN_OFF;
      seg    <= SEG_OFF;
      seg_dp <= SEG_DP_OFF;
      frame  <= 1'b0;
    end else begin
      an     <= an_next ^ AN_OFF;
      seg    <= (lit ? hex_seg : 7'h00) ^ SEG_OFF;
      seg_dp <= (lit & act_dp_reg[d_reg]) ^ SEG_DP_OFF;
      frame  <= (pre_reg == '0) && (s_reg == '0) && (d_reg == '0);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised bench for seven_seg_scan; expected pins come from a cycle-count
// model of the scan position plus a frame-level shadow/active bank model.
module tb_seven_seg_scan;

  localparam int DIGITS    = 4;
  localparam int CLKSPEED  = 16;
  localparam int SCAN_HZ   = 1;
  localparam int DUTY_BITS = 2;
  localparam int DIV       = 4;
  localparam int SUBS      = 4;
  localparam int SLOT      = DIV * SUBS;
  localparam int FRAME     = SLOT * DIGITS;

  logic        clk;
  logic        reset_b;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [1:0]  duty;
  logic        load;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame;

  seven_seg_scan #(
    .DIGITS(DIGITS), .CLKSPEED(CLKSPEED), .SCAN_HZ(SCAN_HZ),
    .DUTY_BITS(DUTY_BITS), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_b(reset_b), .value(value), .dp(dp), .blank(blank),
    .duty(duty), .load(load), .seg(seg), .seg_dp(seg_dp), .an(an), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          n_checks;
  int          n_fail;
  int          cyc;
  logic [15:0] m_sh_value, m_act_value;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_blank, m_act_blank;
  logic [1:0]  m_sh_duty, m_act_duty;
  bit          m_pending;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_frame;

  function automatic void model_reset();
    cyc         = 0;
    m_sh_value  = '0; m_sh_dp = '0; m_sh_blank = '0; m_sh_duty = '0;
    m_act_value = '0; m_act_dp = '0; m_act_blank = 4'hF; m_act_duty = '0;
    m_pending   = 1'b0;
  endfunction

  // Expected pins after the coming edge reflect scan position `cyc`, then
  // the bank model absorbs whatever happens on that edge.
  task automatic tick_clk();
    int         s_i;
    int         d_i;
    bit         lit_i;
    logic [3:0] oh;
    s_i   = (cyc / DIV) % SUBS;
    d_i   = (cyc / SLOT) % DIGITS;
    lit_i = !m_act_blank[d_i] && (s_i >= 1) && (s_i <= int'(m_act_duty));
    oh    = 4'b0001 << d_i;
    exp_an    = lit_i ? ~oh : 4'hF;
    exp_seg   = lit_i ? ~hex_tab[m_act_value[d_i*4 +: 4]] : 7'h7F;
    exp_dp    = lit_i ? ~m_act_dp[d_i] : 1'b1;
    exp_frame = ((cyc % FRAME) == 0);
    if (((cyc + 1) % FRAME) == 0 && m_pending) begin
      m_act_value = m_sh_value; m_act_dp = m_sh_dp;
      m_act_blank = m_sh_blank; m_act_duty = m_sh_duty;
      m_pending   = 1'b0;
    end
    if (load) begin
      m_sh_value = value; m_sh_dp = dp; m_sh_blank = blank; m_sh_duty = duty;
      m_pending  = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    load = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b,
                         input logic [1:0] du);
    value = v; dp = p; blank = b; duty = du; load = 1'b1;
    $display("load value=%h dp=%b blank=%b duty=%0d at cyc=%0d", v, p, b, du, cyc);
  endtask

  task automatic test_reset();
    int frames;
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({an, seg, seg_dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_pins got an=%h seg=%h dp=%b fr=%b want an=f seg=7f dp=1 fr=0",
               an, seg, seg_dp, frame);
    end
    reset_b = 1'b1;
    model_reset();
    frames = 0;
    for (int i = 0; i < 200; i++) begin
      tick_clk();
      frames += int'(frame);
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL idle cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    n_checks++;
    if (frames != 4) begin
      n_fail++;
      $display("FAIL frame_count got %0d want 4", frames);
    end
  endtask

  task automatic test_basic();
    int low0;
    do_load(16'h3210, 4'h0, 4'h0, 2'd3);
    do begin
      tick_clk();
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL basic_align cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end while ((cyc % FRAME) != 0);
    low0 = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick_clk();
      low0 += int'(!an[0]);
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    n_checks++;
    if (low0 != 12) begin
      n_fail++;
      $display("FAIL basic_an0_lit got %0d want 12", low0);
    end
  endtask

  task automatic test_duty();
    int low0;
    int lit_all;
    for (int du = 1; du >= 0; du--) begin
      do_load(16'h3210, 4'h0, 4'h0, 2'(du));
      do begin
        tick_clk();
        n_checks++;
        if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
          n_fail++;
          $display("FAIL duty_align cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                   an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
        end
      end while ((cyc % FRAME) != 0);
      low0 = 0;
      lit_all = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick_clk();
        low0    += int'(!an[0]);
        lit_all += int'(an != 4'hF);
        n_checks++;
        if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
          n_fail++;
          $display("FAIL duty%0d cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", du, cyc,
                   an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
        end
      end
      n_checks++;
      if (low0 != 4 * du || lit_all != 16 * du) begin
        n_fail++;
        $display("FAIL duty%0d_lit got an0=%0d all=%0d want an0=%0d all=%0d",
                 du, low0, lit_all, 4 * du, 16 * du);
      end
    end
  endtask

  task automatic test_blank_dp();
    int lit2;
    int dp_bad;
    int dp_low;
    do_load(16'($urandom), 4'b0001, 4'b0100, 2'd3);
    do begin
      tick_clk();
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL blank_align cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end while ((cyc % FRAME) != 0);
    lit2 = 0; dp_bad = 0; dp_low = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick_clk();
      lit2   += int'(!an[2]);
      dp_low += int'(!seg_dp);
      dp_bad += int'(!seg_dp && an[0]);
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL blank cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    n_checks++;
    if (lit2 != 0 || dp_bad != 0 || dp_low != 12) begin
      n_fail++;
      $display("FAIL blank_dp_counts got an2_lit=%0d dp_stray=%0d dp_low=%0d want 0/0/12",
               lit2, dp_bad, dp_low);
    end
  endtask

  task automatic test_boundary_load();
    logic [15:0] va;
    logic [15:0] vb;
    int          bad_a;
    int          bad_b;
    va = 16'($urandom);
    vb = va ^ 16'h1111;
    while ((cyc % FRAME) != 20) begin
      tick_clk();
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL bnd_pre cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    do_load(va, 4'h0, 4'h0, 2'd3);
    do begin
      tick_clk();
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL bnd_mid cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end while ((cyc % FRAME) != FRAME - 1);
    // This load lands on the very edge that transfers the previous shadow.
    do_load(vb, 4'h0, 4'h0, 2'd3);
    bad_a = 0; bad_b = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == FRAME + 20) do_load(16'($urandom), 4'hF, 4'h0, 2'd2);
      if (i == FRAME + 30) do_load(16'($urandom), 4'h0, 4'h0, 2'd3);
      tick_clk();
      if (an == 4'hE && i >= 1 && i <= FRAME)
        bad_a += int'(seg !== ~hex_tab[va[3:0]]);
      if (an == 4'hE && i > FRAME)
        bad_b += int'(seg !== ~hex_tab[vb[3:0]]);
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL bnd cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    n_checks++;
    if (bad_a != 0 || bad_b != 0) begin
      n_fail++;
      $display("FAIL bnd_order got old_frame_bad=%0d new_frame_bad=%0d want 0/0", bad_a, bad_b);
    end
  endtask

  task automatic test_random();
    int gap;
    for (int k = 0; k < 8; k++) begin
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
      gap = $urandom_range(1, 100);
      for (int i = 0; i < gap; i++) begin
        tick_clk();
        n_checks++;
        if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
          n_fail++;
          $display("FAIL random cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                   an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(16'h7654, 4'hF, 4'h0, 2'd3);
    for (int i = 0; i < 2 * FRAME && !((cyc % FRAME) == 40 && i > FRAME); i++) begin
      tick_clk();
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL arst_pre cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    n_checks++;
    if (an !== 4'b1011) begin
      n_fail++;
      $display("FAIL arst_digit2_lit got an=%b want 1011", an);
    end
    #2;
    reset_b = 1'b0;
    #1;
    n_checks++;
    if ({an, seg, seg_dp, frame} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL arst_immediate got %h/%h/%b/%b want f/7f/1/0", an, seg, seg_dp, frame);
    end
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME + 8; i++) begin
      tick_clk();
      n_checks++;
      if ({an, seg, seg_dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_fail++;
        $display("FAIL arst_post cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b", cyc,
                 an, seg, seg_dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_b  = 1'b0;
    value    = '0;
    dp       = '0;
    blank    = '0;
    duty     = '0;
    load     = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_duty();
    test_blank_dp();
    test_boundary_load();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
